moldudp64_header: RTL and testbench

- Ingress stage of the MoldUDP64 receive path. Sits between the UDP payload extractor and the downstream message block.
- Parses the 20-byte MoldUDP64 header (session 10 B, sequence 8 B, message count 2 B) and tracks the expected sequence number per session.
- Flags gaps, duplicates, session changes and end-of-session.
- Forwards the message-block payload, byte-lane masked, to the message block, which splits it into individual length-prefixed messages.

---
 rtl/moldudp64_header.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_moldudp64_header.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moldudp64_header.sv
// -----------------------------------------------------------------------------
// moldudp64_header
//
// Purpose:
//   Ingress stage of the MoldUDP64 receive path. Parses the 20-byte header
//   (session 10 B, sequence 8 B, message count 2 B) that arrives over three
//   64-bit beats. It tracks the expected sequence number of the current
//   session and classifies each packet as in-order, gap, duplicate, partial
//   overlap, session change or end-of-session. The message-block payload is
//   forwarded to the downstream message splitter with its byte lanes masked
//   but not shifted.
//
// Ports:
//   clk, nreset            clock, asynchronous active-low reset
//   udp_valid_i/start/last  input beat qualifiers (no backpressure)
//   udp_data_i/keep_i       input beat, lane 0 = first wire byte
//   hdr_valid_o             one-cycle pulse, header fields below are fresh
//   sid_o/seq_o/cnt_o       decoded header fields (big-endian), held
//   skip_o                  leading messages to discard on partial overlap
//   gap_o/dup_o/sess_chg_o/eos_o/err_o   one-cycle status pulses
//   mold_valid/start/last/data/keep_o    forwarded payload beats
// -----------------------------------------------------------------------------
module moldudp64_header #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8,
    parameter int SEQ_W  = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              udp_valid_i,
    input  logic              udp_start_i,
    input  logic              udp_last_i,
    input  logic [DATA_W-1:0] udp_data_i,
    input  logic [KEEP_W-1:0] udp_keep_i,
    output logic              hdr_valid_o,
    output logic [79:0]       sid_o,
    output logic [SEQ_W-1:0]  seq_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic [CNT_W-1:0]  skip_o,
    output logic              gap_o,
    output logic              dup_o,
    output logic              sess_chg_o,
    output logic              eos_o,
    output logic              err_o,
    output logic              mold_valid_o,
    output logic              mold_start_o,
    output logic              mold_last_o,
    output logic [DATA_W-1:0] mold_data_o,
    output logic [KEEP_W-1:0] mold_keep_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR1 = 3'd1,
        ST_HDR2 = 3'd2,
        ST_FWD  = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    // Reverse the byte order of a beat: wire byte 0 (lane 0) lands in the MSB.
    function automatic logic [63:0] bswap64(input logic [63:0] d);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = d[8*(7-i) +: 8];
        end
        return r;
    endfunction

    // Parser and tracking state
    state_t        state_q,   state_d;
    logic [63:0]   beat0_q,   beat0_d;
    logic [63:0]   beat1_q,   beat1_d;
    logic [79:0]   sid_reg_q, sid_reg_d;
    logic [63:0]   exp_seq_q, exp_seq_d;
    logic          synced_q,  synced_d;

    // Registered outputs
    logic          hdr_valid_q,  hdr_valid_d;
    logic [79:0]   sid_q,        sid_d;
    logic [63:0]   seq_q,        seq_d;
    logic [15:0]   cnt_q,        cnt_d;
    logic [15:0]   skip_q,       skip_d;
    logic          gap_q,        gap_d;
    logic          dup_q,        dup_d;
    logic          sess_chg_q,   sess_chg_d;
    logic          eos_q,        eos_d;
    logic          err_q,        err_d;
    logic          mold_valid_q, mold_valid_d;
    logic          mold_start_q, mold_start_d;
    logic          mold_last_q,  mold_last_d;
    logic [63:0]   mold_data_q,  mold_data_d;
    logic [7:0]    mold_keep_q,  mold_keep_d;

    // Header decode and classification (valid only while the HDR2 beat is present)
    logic [79:0]   dec_sid_s;
    logic [63:0]   dec_seq_s;
    logic [15:0]   dec_cnt_s;
    logic [63:0]   dec_inc_s;
    logic [63:0]   dec_end_s;
    logic          sid_match_s;
    logic          cls_new_s;
    logic          cls_gap_s;
    logic          cls_dup_s;
    logic [15:0]   cls_skip_s;
    logic [63:0]   cls_exp_s;
    logic          fwd_s;

    // Assemble the header fields from the two stored beats plus the live HDR2 beat.
    always_comb begin
        dec_sid_s   = {bswap64(beat0_q), beat1_q[7:0], beat1_q[15:8]};
        // seq bytes 0-5 sit in lanes 2-7 of beat 1, bytes 6-7 in lanes 0-1 of beat 2
        dec_seq_s   = bswap64({udp_data_i[15:0], beat1_q[63:16]});
        dec_cnt_s   = {udp_data_i[23:16], udp_data_i[31:24]};
        // the end-of-session marker does not advance the sequence
        dec_inc_s   = (dec_cnt_s == 16'hFFFF) ? 64'd0 : {48'd0, dec_cnt_s};
        dec_end_s   = dec_seq_s + dec_inc_s;
        sid_match_s = synced_q && (dec_sid_s == sid_reg_q);
    end

    // Classify the packet against the tracked expected sequence number.
    always_comb begin
        cls_new_s  = 1'b0;
        cls_gap_s  = 1'b0;
        cls_dup_s  = 1'b0;
        cls_skip_s = 16'd0;
        cls_exp_s  = exp_seq_q;
        if (!sid_match_s) begin
            cls_new_s = 1'b1;
            cls_exp_s = dec_end_s;
        end else if (dec_seq_s == exp_seq_q) begin
            cls_exp_s = dec_end_s;
        end else if (dec_seq_s > exp_seq_q) begin
            cls_gap_s = 1'b1;
            cls_exp_s = dec_end_s;
        end else if (dec_end_s <= exp_seq_q) begin
            cls_dup_s = 1'b1;
        end else begin
            // overlap: exp - seq < cnt, so the low 16 bits carry the full value
            cls_skip_s = exp_seq_q[15:0] - dec_seq_s[15:0];
            cls_exp_s  = dec_end_s;
        end
        fwd_s = !cls_dup_s && (dec_cnt_s != 16'd0);
    end

    // Next-state, tracking update and registered-output computation.
    always_comb begin
        state_d      = state_q;
        beat0_d      = beat0_q;
        beat1_d      = beat1_q;
        sid_reg_d    = sid_reg_q;
        exp_seq_d    = exp_seq_q;
        synced_d     = synced_q;
        hdr_valid_d  = 1'b0;
        sid_d        = sid_q;
        seq_d        = seq_q;
        cnt_d        = cnt_q;
        skip_d       = skip_q;
        gap_d        = 1'b0;
        dup_d        = 1'b0;
        sess_chg_d   = 1'b0;
        eos_d        = 1'b0;
        err_d        = 1'b0;
        mold_valid_d = 1'b0;
        mold_start_d = 1'b0;
        mold_last_d  = 1'b0;
        mold_data_d  = 64'd0;
        mold_keep_d  = 8'd0;

        if (udp_valid_i) begin
            if (udp_start_i) begin
                // a start outside IDLE aborts the packet in flight; no mold_last_o is sent
                if (state_q != ST_IDLE) begin
                    err_d = 1'b1;
                end else begin
                    err_d = 1'b0;
                end
                if (udp_last_i) begin
                    // single-beat packet cannot hold a header
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    beat0_d = udp_data_i;
                    state_d = ST_HDR1;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d = ST_IDLE;
                    end
                    ST_HDR1: begin
                        if (udp_last_i) begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            beat1_d = udp_data_i;
                            state_d = ST_HDR2;
                        end
                    end
                    ST_HDR2: begin
                        if (udp_keep_i[3:0] != 4'hF) begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            hdr_valid_d = 1'b1;
                            sid_d       = dec_sid_s;
                            seq_d       = dec_seq_s;
                            cnt_d       = dec_cnt_s;
                            skip_d      = cls_skip_s;
                            gap_d       = cls_gap_s;
                            dup_d       = cls_dup_s;
                            sess_chg_d  = cls_new_s && synced_q;
                            exp_seq_d   = cls_exp_s;
                            if (cls_new_s) begin
                                synced_d  = 1'b1;
                                sid_reg_d = dec_sid_s;
                            end else begin
                                synced_d  = synced_q;
                            end
                            // end-of-session drops sync after the sequence update
                            if (dec_cnt_s == 16'hFFFF) begin
                                eos_d    = 1'b1;
                                synced_d = 1'b0;
                            end else begin
                                eos_d    = 1'b0;
                            end
                            // lanes 4-7 of this beat open the message block
                            if (fwd_s && (udp_keep_i[7:4] != 4'h0)) begin
                                mold_valid_d = 1'b1;
                                mold_start_d = 1'b1;
                                mold_last_d  = udp_last_i;
                                mold_data_d  = udp_data_i;
                                mold_keep_d  = udp_keep_i & 8'hF0;
                            end else begin
                                mold_valid_d = 1'b0;
                            end
                            if (udp_last_i) begin
                                state_d = ST_IDLE;
                            end else if (fwd_s) begin
                                state_d = ST_FWD;
                            end else begin
                                state_d = ST_DROP;
                            end
                        end
                    end
                    ST_FWD: begin
                        mold_valid_d = 1'b1;
                        mold_last_d  = udp_last_i;
                        mold_data_d  = udp_data_i;
                        mold_keep_d  = udp_keep_i;
                        if (udp_last_i) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_FWD;
                        end
                    end
                    ST_DROP: begin
                        if (udp_last_i) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end else begin
            // no beat: every state holds
            state_d = state_q;
        end
    end

    // State, tracking and output registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= ST_IDLE;
            beat0_q      <= 64'd0;
            beat1_q      <= 64'd0;
            sid_reg_q    <= 80'd0;
            exp_seq_q    <= 64'd0;
            synced_q     <= 1'b0;
            hdr_valid_q  <= 1'b0;
            sid_q        <= 80'd0;
            seq_q        <= 64'd0;
            cnt_q        <= 16'd0;
            skip_q       <= 16'd0;
            gap_q        <= 1'b0;
            dup_q        <= 1'b0;
            sess_chg_q   <= 1'b0;
            eos_q        <= 1'b0;
            err_q        <= 1'b0;
            mold_valid_q <= 1'b0;
            mold_start_q <= 1'b0;
            mold_last_q  <= 1'b0;
            mold_data_q  <= 64'd0;
            mold_keep_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            beat0_q      <= beat0_d;
            beat1_q      <= beat1_d;
            sid_reg_q    <= sid_reg_d;
            exp_seq_q    <= exp_seq_d;
            synced_q     <= synced_d;
            hdr_valid_q  <= hdr_valid_d;
            sid_q        <= sid_d;
            seq_q        <= seq_d;
            cnt_q        <= cnt_d;
            skip_q       <= skip_d;
            gap_q        <= gap_d;
            dup_q        <= dup_d;
            sess_chg_q   <= sess_chg_d;
            eos_q        <= eos_d;
            err_q        <= err_d;
            mold_valid_q <= mold_valid_d;
            mold_start_q <= mold_start_d;
            mold_last_q  <= mold_last_d;
            mold_data_q  <= mold_data_d;
            mold_keep_q  <= mold_keep_d;
        end
    end

    assign hdr_valid_o  = hdr_valid_q;
    assign sid_o        = sid_q;
    assign seq_o        = seq_q;
    assign cnt_o        = cnt_q;
    assign skip_o       = skip_q;
    assign gap_o        = gap_q;
    assign dup_o        = dup_q;
    assign sess_chg_o   = sess_chg_q;
    assign eos_o        = eos_q;
    assign err_o        = err_q;
    assign mold_valid_o = mold_valid_q;
    assign mold_start_o = mold_start_q;
    assign mold_last_o  = mold_last_q;
    assign mold_data_o  = mold_data_q;
    assign mold_keep_o  = mold_keep_q;

endmodule

// File: tb/tb_moldudp64_header.sv
// -----------------------------------------------------------------------------
// tb_moldudp64_header
//
// Self-checking bench for moldudp64_header. Packets are built as byte queues,
// driven beat by beat, and the observed header events / payload beats are
// compared with a packet-level reference model of the sequence tracking rules.
// -----------------------------------------------------------------------------
module tb_moldudp64_header;

    logic        clk = 1'b0;
    logic        nreset;
    logic        udp_valid_i, udp_start_i, udp_last_i;
    logic [63:0] udp_data_i;
    logic [7:0]  udp_keep_i;
    logic        hdr_valid_o;
    logic [79:0] sid_o;
    logic [63:0] seq_o;
    logic [15:0] cnt_o, skip_o;
    logic        gap_o, dup_o, sess_chg_o, eos_o, err_o;
    logic        mold_valid_o, mold_start_o, mold_last_o;
    logic [63:0] mold_data_o;
    logic [7:0]  mold_keep_o;

    always #5 clk = ~clk;

    moldudp64_header dut (
        .clk          (clk),
        .nreset       (nreset),
        .udp_valid_i  (udp_valid_i),
        .udp_start_i  (udp_start_i),
        .udp_last_i   (udp_last_i),
        .udp_data_i   (udp_data_i),
        .udp_keep_i   (udp_keep_i),
        .hdr_valid_o  (hdr_valid_o),
        .sid_o        (sid_o),
        .seq_o        (seq_o),
        .cnt_o        (cnt_o),
        .skip_o       (skip_o),
        .gap_o        (gap_o),
        .dup_o        (dup_o),
        .sess_chg_o   (sess_chg_o),
        .eos_o        (eos_o),
        .err_o        (err_o),
        .mold_valid_o (mold_valid_o),
        .mold_start_o (mold_start_o),
        .mold_last_o  (mold_last_o),
        .mold_data_o  (mold_data_o),
        .mold_keep_o  (mold_keep_o)
    );

    // flags = {gap, dup, sess_chg, eos}
    typedef struct {
        logic [79:0] sid;
        logic [63:0] seq;
        logic [15:0] cnt;
        logic [15:0] skip;
        logic [3:0]  flags;
    } hdr_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        start;
        logic        last;
    } beat_t;

    hdr_t        obs_hdr[$], exp_hdr[$];
    beat_t       obs_beat[$], exp_beat[$];
    int          obs_err, exp_err;
    int          n_checks, n_errors;
    logic [7:0]  pkt_q[$];

    // reference tracking state
    logic [63:0] m_exp;
    logic        m_synced;
    logic [79:0] m_sid;

    logic [79:0] sid_a = "SESSION001";
    logic [79:0] sid_b = "SESSION002";

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and record what the DUT produced on it.
    task automatic tick();
        hdr_t  h;
        beat_t b;
        @(negedge clk);
        if (hdr_valid_o) begin
            h.sid   = sid_o;
            h.seq   = seq_o;
            h.cnt   = cnt_o;
            h.skip  = skip_o;
            h.flags = {gap_o, dup_o, sess_chg_o, eos_o};
            obs_hdr.push_back(h);
        end
        if (mold_valid_o) begin
            b.data  = mold_data_o;
            b.keep  = mold_keep_o;
            b.start = mold_start_o;
            b.last  = mold_last_o;
            obs_beat.push_back(b);
        end
        if (err_o) obs_err++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_beat(input logic s, input logic l, input logic [63:0] d, input logic [7:0] k);
        udp_valid_i = 1'b1;
        udp_start_i = s;
        udp_last_i  = l;
        udp_data_i  = d;
        udp_keep_i  = k;
        tick();
        udp_valid_i = 1'b0;
        udp_start_i = 1'b0;
        udp_last_i  = 1'b0;
        udp_keep_i  = 8'h00;
    endtask

    task automatic build_pkt(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt, input int paylen);
        pkt_q.delete();
        for (int i = 0; i < 10; i++) pkt_q.push_back(sid[79-8*i -: 8]);
        for (int i = 0; i < 8; i++)  pkt_q.push_back(seq[63-8*i -: 8]);
        pkt_q.push_back(cnt[15:8]);
        pkt_q.push_back(cnt[7:0]);
        for (int i = 0; i < paylen; i++) pkt_q.push_back(8'($urandom));
    endtask

    // Drive the first nsend beats of pkt_q with gap_lo..gap_hi idle cycles between beats.
    task automatic send_pkt(input int nsend, input int gap_lo, input int gap_hi);
        int len;
        int nb;
        len = pkt_q.size();
        nb  = (len + 7) / 8;
        for (int b = 0; b < nb && b < nsend; b++) begin
            logic [63:0] d;
            logic [7:0]  k;
            if (b > 0) idle(int'($urandom_range(gap_hi, gap_lo)));
            for (int l = 0; l < 8; l++) begin
                if (8*b + l < len) begin
                    d[8*l +: 8] = pkt_q[8*b + l];
                    k[l]        = 1'b1;
                end else begin
                    d[8*l +: 8] = 8'($urandom);
                    k[l]        = 1'b0;
                end
            end
            drive_beat(b == 0, b == nb - 1, d, k);
            if (b == 1) chk("hdr_early", 256'(hdr_valid_o), 256'(0));
            if (b == 2) chk("hdr_pulse", 256'(hdr_valid_o), 256'(len >= 20));
        end
    endtask

    // Packet-level reference: classify pkt_q and queue the expected outputs.
    task automatic model_pkt(input int nsend);
        logic [79:0] sid;
        logic [63:0] seq, inc, en;
        logic [15:0] cnt;
        hdr_t        h;
        beat_t       bt;
        bit          fwd, first;
        int          len, nb, sent;
        len = pkt_q.size();
        nb  = (len + 7) / 8;
        sid = '0;
        seq = '0;
        for (int i = 0; i < 10; i++) sid = {sid[71:0], pkt_q[i]};
        for (int i = 10; i < 18; i++) seq = {seq[55:0], pkt_q[i]};
        cnt = {pkt_q[18], pkt_q[19]};
        inc = (cnt == 16'hFFFF) ? 64'd0 : 64'(cnt);
        en  = seq + inc;
        h.sid = sid; h.seq = seq; h.cnt = cnt; h.skip = 16'd0; h.flags = 4'd0;
        fwd = 1'b1;
        if (!m_synced || sid != m_sid) begin
            h.flags[1] = m_synced;
            m_exp = en; m_synced = 1'b1; m_sid = sid;
        end else if (seq == m_exp) begin
            m_exp = en;
        end else if (seq > m_exp) begin
            h.flags[3] = 1'b1;
            m_exp = en;
        end else if (en <= m_exp) begin
            h.flags[2] = 1'b1;
            fwd = 1'b0;
        end else begin
            h.skip = 16'(m_exp - seq);
            m_exp = en;
        end
        if (cnt == 16'hFFFF) begin
            h.flags[0] = 1'b1;
            m_synced = 1'b0;
        end
        if (cnt == 16'd0) fwd = 1'b0;
        exp_hdr.push_back(h);
        sent  = (nsend < nb) ? nsend : nb;
        first = 1'b1;
        if (fwd) begin
            for (int b = 2; b < sent; b++) begin
                bt.keep = 8'h00;
                bt.data = 64'd0;
                for (int l = 0; l < 8; l++) begin
                    if (8*b + l < len && !(b == 2 && l < 4)) begin
                        bt.keep[l]       = 1'b1;
                        bt.data[8*l +: 8] = pkt_q[8*b + l];
                    end
                end
                if (bt.keep != 8'h00) begin
                    bt.start = first;
                    bt.last  = (b == nb - 1);
                    first    = 1'b0;
                    exp_beat.push_back(bt);
                end
            end
        end
    endtask

    task automatic check_all();
        logic [63:0] m;
        chk("hdr_count", 256'(obs_hdr.size()), 256'(exp_hdr.size()));
        for (int i = 0; i < obs_hdr.size() && i < exp_hdr.size(); i++) begin
            chk("hdr_sid",   256'(obs_hdr[i].sid),   256'(exp_hdr[i].sid));
            chk("hdr_seq",   256'(obs_hdr[i].seq),   256'(exp_hdr[i].seq));
            chk("hdr_cnt",   256'(obs_hdr[i].cnt),   256'(exp_hdr[i].cnt));
            chk("hdr_skip",  256'(obs_hdr[i].skip),  256'(exp_hdr[i].skip));
            chk("hdr_flags", 256'(obs_hdr[i].flags), 256'(exp_hdr[i].flags));
        end
        if (exp_hdr.size() > 0) chk("sid_hold", 256'(sid_o), 256'(exp_hdr[$].sid));
        chk("beat_count", 256'(obs_beat.size()), 256'(exp_beat.size()));
        for (int i = 0; i < obs_beat.size() && i < exp_beat.size(); i++) begin
            for (int l = 0; l < 8; l++) m[8*l +: 8] = {8{exp_beat[i].keep[l]}};
            chk("beat_keep",  256'(obs_beat[i].keep),     256'(exp_beat[i].keep));
            chk("beat_start", 256'(obs_beat[i].start),    256'(exp_beat[i].start));
            chk("beat_last",  256'(obs_beat[i].last),     256'(exp_beat[i].last));
            chk("beat_data",  256'(obs_beat[i].data & m), 256'(exp_beat[i].data));
        end
        chk("err_count", 256'(obs_err), 256'(exp_err));
        obs_hdr.delete(); exp_hdr.delete(); obs_beat.delete(); exp_beat.delete();
        obs_err = 0; exp_err = 0;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk(tag, 256'({hdr_valid_o, sid_o, seq_o, cnt_o, skip_o, gap_o, dup_o, sess_chg_o,
                       eos_o, err_o, mold_valid_o, mold_start_o, mold_last_o, mold_data_o,
                       mold_keep_o}), 256'(0));
    endtask

    task automatic full_pkt(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt,
                            input int paylen, input int gap_lo, input int gap_hi);
        build_pkt(sid, seq, cnt, paylen);
        send_pkt(99, gap_lo, gap_hi);
        model_pkt(99);
        idle(1);
        check_all();
    endtask

    initial begin
        n_checks = 0; n_errors = 0; obs_err = 0; exp_err = 0;
        udp_valid_i = 1'b0; udp_start_i = 1'b0; udp_last_i = 1'b0;
        udp_data_i = 64'd0; udp_keep_i = 8'h00;
        m_exp = 64'd0; m_synced = 1'b0; m_sid = 80'd0;
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        chk_outs_zero("reset_outputs");
        nreset = 1'b1;
        idle(2);

        // in-order first packet, gap, duplicate, overlap
        full_pkt(sid_a, 64'd1, 16'd2, 30, 0, 0);
        full_pkt(sid_a, 64'd5, 16'd1, 12, 0, 0);
        full_pkt(sid_a, 64'd3, 16'd2, 16, 0, 0);
        full_pkt(sid_a, 64'd4, 16'd4, 20, 0, 0);
        // heartbeat, end-of-session, resync after it
        full_pkt(sid_a, 64'd8, 16'd0, 0, 0, 0);
        full_pkt(sid_a, 64'd8, 16'hFFFF, 0, 0, 0);
        full_pkt(sid_a, 64'd100, 16'd3, 10, 0, 0);
        // session change while synced, and payload ending inside beat 2
        full_pkt(sid_b, 64'd7, 16'd1, 3, 0, 0);
        full_pkt(sid_a, 64'd50, 16'd2, 4, 0, 0);

        // truncated on beat 1
        build_pkt(sid_a, 64'd200, 16'd1, 8);
        pkt_q = pkt_q[0:15];
        send_pkt(99, 0, 0);
        exp_err = 1;
        idle(1);
        check_all();
        // beat 2 with keep 0x03
        build_pkt(sid_a, 64'd200, 16'd1, 8);
        pkt_q = pkt_q[0:17];
        send_pkt(99, 0, 0);
        exp_err = 1;
        idle(1);
        check_all();

        // start arrives during FWD: abort, then the new packet parses
        build_pkt(sid_a, m_exp, 16'd2, 40);
        send_pkt(4, 0, 0);
        model_pkt(4);
        build_pkt(sid_a, m_exp, 16'd1, 10);
        send_pkt(99, 0, 0);
        exp_err++;
        model_pkt(99);
        idle(1);
        check_all();

        // 3-cycle valid gaps inside the header
        full_pkt(sid_a, m_exp + 64'd5, 16'd2, 20, 3, 3);

        // reset while forwarding
        build_pkt(sid_a, m_exp, 16'd3, 40);
        send_pkt(5, 0, 0);
        model_pkt(5);
        chk("fwd_before_reset", 256'(mold_valid_o), 256'(1));
        check_all();
        #1 nreset = 1'b0;
        #1 chk_outs_zero("reset_mid_fwd");
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        m_exp = 64'd0; m_synced = 1'b0; m_sid = 80'd0;
        idle(1);
        full_pkt(sid_a, 64'd50, 16'd2, 12, 0, 0);

        // randomized traffic around the expected sequence number
        for (int p = 0; p < 40; p++) begin
            logic [79:0] s;
            logic [63:0] sq;
            logic [15:0] c;
            s  = ($urandom_range(0, 7) == 0) ? sid_b : sid_a;
            sq = m_exp + 64'($urandom_range(0, 8)) - 64'd4;
            c  = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 4));
            full_pkt(s, sq, c, int'($urandom_range(0, 30)), 0, 2);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
